// File: rtl/mem_ctrl.sv
// Serialises 32-bit fetch and load/store requests onto a byte-wide synchronous RAM port.
// A read of N bytes is done N+1 cycles after accept, a write N cycles after; rdy low freezes everything.
module mem_ctrl #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [1:0] ST_INIT = 2'b00,
  parameter logic [1:0] ST_BUSY = 2'b01,
  parameter logic [1:0] ST_DONE = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic [1:0]        if_status_o,
  input  logic [1:0]        ls_readwrite_i,
  input  logic [2:0]        ls_times_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [1:0]        ls_status_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [2:0]        r_n, w_n_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              r_is_ls, w_is_ls_nxt;
  logic [DATA_W-1:0] r_rbuf, w_rbuf_nxt;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]        r_mem_dout, w_mem_dout_nxt;
  logic              r_mem_wr, w_mem_wr_nxt;
  logic [DATA_W-1:0] r_if_data, w_if_data_nxt;
  logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata_nxt;
  logic [1:0]        r_if_status, w_if_status_nxt;
  logic [1:0]        r_ls_status, w_ls_status_nxt;

  logic              w_ls_vld;
  logic [2:0]        w_edge;
  logic [1:0]        w_byte;
  logic [ADDR_W-1:0] w_addr_inc;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_n_nxt         = r_n;
    w_cnt_nxt       = r_cnt;
    w_is_ls_nxt     = r_is_ls;
    w_rbuf_nxt      = r_rbuf;
    w_mem_a_nxt     = r_mem_a;
    w_mem_dout_nxt  = r_mem_dout;
    w_mem_wr_nxt    = r_mem_wr;
    w_if_data_nxt   = r_if_data;
    w_ls_rdata_nxt  = r_ls_rdata;
    w_if_status_nxt = r_if_status;
    w_ls_status_nxt = r_ls_status;

    w_ls_vld   = ((ls_readwrite_i == 2'b01) || (ls_readwrite_i == 2'b10)) &&
                 ((ls_times_i == 3'd1) || (ls_times_i == 3'd2) || (ls_times_i == 3'd4));
    // r_cnt counts edges since accept, so w_edge is the index of the edge being taken now
    w_edge     = r_cnt + 3'd1;
    w_byte     = r_cnt[1:0] - 2'd1;
    w_addr_inc = r_addr + ADDR_W'(w_edge);

    case (r_state)
      S_IDLE: begin
        w_mem_wr_nxt = 1'b0;
        if (w_ls_vld) begin
          w_is_ls_nxt     = 1'b1;
          w_addr_nxt      = ls_addr_i;
          w_n_nxt         = ls_times_i;
          w_wdata_nxt     = ls_wdata_i;
          w_cnt_nxt       = 3'd0;
          w_rbuf_nxt      = '0;
          w_mem_a_nxt     = ls_addr_i;
          w_ls_status_nxt = ST_BUSY;
          w_if_status_nxt = ST_INIT;
          if (ls_readwrite_i == 2'b10) begin
            w_mem_dout_nxt = ls_wdata_i[7:0];
            w_mem_wr_nxt   = 1'b1;
            w_state_nxt    = S_WRITE;
          end else begin
            w_state_nxt = S_READ;
          end
        end else if (if_req_i) begin
          w_is_ls_nxt     = 1'b0;
          w_addr_nxt      = if_addr_i;
          w_n_nxt         = 3'd4;
          w_cnt_nxt       = 3'd0;
          w_rbuf_nxt      = '0;
          w_mem_a_nxt     = if_addr_i;
          w_if_status_nxt = ST_BUSY;
          w_ls_status_nxt = ST_INIT;
          w_state_nxt     = S_READ;
        end
      end

      S_READ: begin
        w_cnt_nxt = w_edge;
        if (w_edge < r_n) begin
          w_mem_a_nxt = w_addr_inc;
        end
        // the RAM answers one cycle after the address, so byte i lands two edges after it was issued
        if (w_edge >= 3'd2) begin
          w_rbuf_nxt[{w_byte, 3'b000} +: 8] = mem_din;
        end
        if (w_edge == r_n + 3'd1) begin
          w_state_nxt = S_DONE;
          if (r_is_ls) begin
            w_ls_rdata_nxt  = w_rbuf_nxt;
            w_ls_status_nxt = ST_DONE;
          end else begin
            w_if_data_nxt   = w_rbuf_nxt;
            w_if_status_nxt = ST_DONE;
          end
        end
      end

      S_WRITE: begin
        w_cnt_nxt = w_edge;
        if (w_edge < r_n) begin
          w_mem_a_nxt    = w_addr_inc;
          w_mem_dout_nxt = r_wdata[{w_edge[1:0], 3'b000} +: 8];
          w_mem_wr_nxt   = 1'b1;
        end else begin
          w_mem_wr_nxt    = 1'b0;
          w_state_nxt     = S_DONE;
          w_ls_status_nxt = ST_DONE;
        end
      end

      S_DONE: begin
        w_mem_wr_nxt    = 1'b0;
        w_if_status_nxt = ST_INIT;
        w_ls_status_nxt = ST_INIT;
        w_state_nxt     = S_IDLE;
      end

      default: begin
        w_mem_wr_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_n         <= '0;
      r_cnt       <= '0;
      r_is_ls     <= 1'b0;
      r_rbuf      <= '0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_if_data   <= '0;
      r_ls_rdata  <= '0;
      r_if_status <= ST_INIT;
      r_ls_status <= ST_INIT;
    end else if (rdy) begin
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_n         <= w_n_nxt;
      r_cnt       <= w_cnt_nxt;
      r_is_ls     <= w_is_ls_nxt;
      r_rbuf      <= w_rbuf_nxt;
      r_mem_a     <= w_mem_a_nxt;
      r_mem_dout  <= w_mem_dout_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_if_data   <= w_if_data_nxt;
      r_ls_rdata  <= w_ls_rdata_nxt;
      r_if_status <= w_if_status_nxt;
      r_ls_status <= w_ls_status_nxt;
    end
  end

  assign if_data_o   = r_if_data;
  assign if_status_o = r_if_status;
  assign ls_rdata_o  = r_ls_rdata;
  assign ls_status_o = r_ls_status;
  assign mem_a       = r_mem_a;
  assign mem_dout    = r_mem_dout;
  // the RAM shares rdy, so a stalled write strobe must never reach it
  assign mem_wr      = r_mem_wr & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, hand-written corner sequences and
// randomized transactions scored against a byte-array memory model.
module tb_mem_ctrl;

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic [1:0]  if_status_o;
  logic [1:0]  ls_readwrite_i;
  logic [2:0]  ls_times_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [31:0] ls_rdata_o;
  logic [1:0]  ls_status_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int checks = 0;
  int errors = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_status_o(if_status_o),
    .ls_readwrite_i(ls_readwrite_i), .ls_times_i(ls_times_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_rdata_o(ls_rdata_o), .ls_status_o(ls_status_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM seen by the DUT (read-first, one cycle latency, frozen by rdy) and the expected memory image
  logic [7:0] ram  [bit [31:0]];
  logic [7:0] refm [bit [31:0]];

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog[$];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  initial mem_din = 8'h00;
  always @(posedge clk) begin
    wr_t e;
    if (rdy) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        e.a = mem_a;
        e.d = mem_dout;
        wlog.push_back(e);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    refm[a] = d;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r = r | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    if_req_i       = 1'b0;
    ls_readwrite_i = 2'b00;
    ls_times_i     = 3'd0;
  endtask

  task automatic wait_done(input bit is_ls, output int k);
    k = 0;
    while (k < 50) begin
      tick();
      k++;
      if ((is_ls ? ls_status_o : if_status_o) == ST_DONE) return;
    end
  endtask

  // one complete transaction; rnd enables rdy stalls and request noise while busy
  task automatic do_txn(input string nm, input bit is_ls, input bit is_wr, input int n,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int base_lat, input logic [31:0] exp_data, input bit rnd);
    int k, stalls, j, m;
    bit done, rv;
    logic [1:0]  own;
    logic [31:0] own_before, oth_before, own_d, oth_d, wd;
    own_before = is_ls ? ls_rdata_o : if_data_o;
    oth_before = is_ls ? if_data_o : ls_rdata_o;
    if (is_ls) begin
      if_req_i       = 1'b0;
      ls_readwrite_i = is_wr ? 2'b10 : 2'b01;
      ls_times_i     = 3'(n);
      ls_addr_i      = addr;
      ls_wdata_i     = wdata;
    end else begin
      ls_readwrite_i = 2'b00;
      if_req_i       = 1'b1;
      if_addr_i      = addr;
    end
    wlog.delete();
    tick();
    chk({nm, " accept own status"}, 32'(is_ls ? ls_status_o : if_status_o), 32'(ST_BUSY));
    chk({nm, " accept other status"}, 32'(is_ls ? if_status_o : ls_status_o), 32'(ST_INIT));
    chk({nm, " accept mem_a"}, mem_a, addr);
    chk({nm, " accept mem_wr"}, 32'(mem_wr), 32'(is_wr));
    k = 0;
    stalls = 0;
    done = 1'b0;
    while (!done && k < 60) begin
      if (rnd) begin
        ls_readwrite_i = 2'($urandom_range(0, 3));
        ls_times_i     = 3'($urandom_range(0, 7));
        ls_addr_i      = $urandom;
        ls_wdata_i     = $urandom;
        if_req_i       = 1'($urandom_range(0, 1));
        if_addr_i      = $urandom;
      end else begin
        clear_req();
      end
      rv  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = rv;
      if (!rv) stalls++;
      tick();
      k++;
      j = k - stalls;
      m = (j < n - 1) ? j : n - 1;
      own = is_ls ? ls_status_o : if_status_o;
      chk({nm, " other status"}, 32'(is_ls ? if_status_o : ls_status_o), 32'(ST_INIT));
      chk({nm, " mem_a"}, mem_a, addr + 32'(m));
      chk({nm, " mem_wr"}, 32'(mem_wr), 32'(rv && is_wr && (j < n)));
      if (own == ST_DONE) done = 1'b1;
      else chk({nm, " busy status"}, 32'(own), 32'(ST_BUSY));
    end
    rdy = 1'b1;
    chk({nm, " latency"}, 32'(k), 32'(base_lat + stalls));
    own_d = is_ls ? ls_rdata_o : if_data_o;
    oth_d = is_ls ? if_data_o : ls_rdata_o;
    chk({nm, " data"}, own_d, is_wr ? own_before : exp_data);
    chk({nm, " other data held"}, oth_d, oth_before);
    if (is_wr) begin
      chk({nm, " write count"}, 32'(wlog.size()), 32'(n));
      wd = wdata;
      for (int i = 0; i < n; i++) begin
        if (i < wlog.size()) begin
          chk({nm, " write addr"}, wlog[i].a, addr + 32'(i));
          chk({nm, " write byte"}, 32'(wlog[i].d), 32'(wd[8*i +: 8]));
        end
        refm[addr + 32'(i)] = wd[8*i +: 8];
      end
    end
    tick();
    chk({nm, " after if status"}, 32'(if_status_o), 32'(ST_INIT));
    chk({nm, " after ls status"}, 32'(ls_status_o), 32'(ST_INIT));
    chk({nm, " data kept"}, is_ls ? ls_rdata_o : if_data_o, own_d);
    clear_req();
  endtask

  typedef struct {
    bit          is_ls;
    bit          is_wr;
    int          n;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, kk, kind, n;
    bit is_wr, is_ls;
    logic [31:0] addr, wdata, e;
    logic [1:0] inv_rw [6];
    logic [2:0] inv_t [6];

    vecs[0] = '{1'b0, 1'b0, 4, 32'h0000_0100, 32'h0,         5, 32'h0000_0513};
    vecs[1] = '{1'b1, 1'b0, 2, 32'h0000_0020, 32'h0,         3, 32'h0000_80FF};
    vecs[2] = '{1'b1, 1'b1, 1, 32'h0003_0000, 32'h0000_00AB, 1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 4, 32'h0000_0040, 32'h1234_5678, 4, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 4, 32'h0000_0040, 32'h0,         5, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 1, 32'h0000_0042, 32'h0,         2, 32'h0000_0034};
    vecs[6] = '{1'b1, 1'b0, 2, 32'hFFFF_FFFF, 32'h0,         3, 32'h0000_2211};
    vecs[7] = '{1'b1, 1'b0, 1, 32'h0003_0000, 32'h0,         2, 32'h0000_00AB};
    vecs[8] = '{1'b1, 1'b1, 2, 32'h0000_0050, 32'hDEAD_BEEF, 2, 32'h0};
    vecs[9] = '{1'b1, 1'b0, 4, 32'h0000_0050, 32'h0,         5, 32'h0000_BEEF};

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h20, 8'hFF);  preload(32'h21, 8'h80);
    preload(32'hFFFF_FFFF, 8'h11); preload(32'h0, 8'h22);

    rst = 1'b0; rdy = 1'b1;
    if_addr_i = 32'h0; ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    clear_req();
    #1 rst = 1'b1;
    #2;
    chk("reset if_status", 32'(if_status_o), 32'(ST_INIT));
    chk("reset ls_status", 32'(ls_status_o), 32'(ST_INIT));
    chk("reset if_data", if_data_o, 32'h0);
    chk("reset ls_rdata", ls_rdata_o, 32'h0);
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_dout", 32'(mem_dout), 32'h0);
    chk("reset mem_wr", 32'(mem_wr), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].is_ls, vecs[i].is_wr, vecs[i].n, vecs[i].addr,
             vecs[i].wdata, vecs[i].lat, vecs[i].exp, 1'b0);

    // simultaneous requests: load/store first, fetch picked up after DONE
    if_req_i = 1'b1; if_addr_i = 32'h100;
    ls_readwrite_i = 2'b01; ls_times_i = 3'd2; ls_addr_i = 32'h20;
    tick();
    chk("arb ls busy", 32'(ls_status_o), 32'(ST_BUSY));
    chk("arb if waits", 32'(if_status_o), 32'(ST_INIT));
    ls_readwrite_i = 2'b00;
    wait_done(1'b1, k);
    chk("arb ls latency", 32'(k), 32'd3);
    chk("arb ls data", ls_rdata_o, 32'h0000_80FF);
    tick();
    chk("arb idle ls", 32'(ls_status_o), 32'(ST_INIT));
    chk("arb idle if", 32'(if_status_o), 32'(ST_INIT));
    tick();
    chk("arb fetch busy", 32'(if_status_o), 32'(ST_BUSY));
    chk("arb fetch mem_a", mem_a, 32'h100);
    if_req_i = 1'b0;
    wait_done(1'b0, k);
    chk("arb fetch latency", 32'(k), 32'd5);
    chk("arb fetch data", if_data_o, 32'h0000_0513);
    tick();

    // three stalled cycles in the middle of a word load
    ls_readwrite_i = 2'b01; ls_times_i = 3'd4; ls_addr_i = 32'h100;
    tick();
    clear_req();
    tick(); tick();
    k = 2;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      k++;
      chk("stall mem_wr", 32'(mem_wr), 32'h0);
      chk("stall mem_a", mem_a, 32'h102);
      chk("stall ls busy", 32'(ls_status_o), 32'(ST_BUSY));
    end
    rdy = 1'b1;
    wait_done(1'b1, kk);
    chk("stall latency", 32'(k + kk), 32'd8);
    chk("stall data", ls_rdata_o, 32'h0000_0513);
    tick();

    // malformed load/store requests are never accepted
    inv_rw = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    inv_t  = '{3'd0,  3'd3,  3'd5,  3'd7,  3'd4,  3'd1};
    for (int i = 0; i < 6; i++) begin
      ls_readwrite_i = inv_rw[i]; ls_times_i = inv_t[i]; ls_addr_i = 32'h40;
      tick(); tick();
      chk("invalid ls status", 32'(ls_status_o), 32'(ST_INIT));
      chk("invalid if status", 32'(if_status_o), 32'(ST_INIT));
      chk("invalid mem_wr", 32'(mem_wr), 32'h0);
      clear_req();
    end
    tick();

    // asynchronous reset two edges into a word load
    ls_readwrite_i = 2'b01; ls_times_i = 3'd4; ls_addr_i = 32'h40;
    tick();
    clear_req();
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst mem_wr", 32'(mem_wr), 32'h0);
    chk("midrst ls_status", 32'(ls_status_o), 32'(ST_INIT));
    chk("midrst if_status", 32'(if_status_o), 32'(ST_INIT));
    chk("midrst ls_rdata", ls_rdata_o, 32'h0);
    chk("midrst if_data", if_data_o, 32'h0);
    chk("midrst mem_a", mem_a, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    do_txn("post-reset LW", 1'b1, 1'b0, 4, 32'h40, 32'h0, 5, 32'h1234_5678, 1'b0);

    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 6);
      is_ls = (kind != 0);
      is_wr = (kind >= 4);
      n     = (kind == 0) ? 4 : ((kind - 1) % 3 == 2 ? 4 : (kind - 1) % 3 + 1);
      addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : 32'h2000 + 32'($urandom_range(0, 15));
      wdata = $urandom;
      e     = is_wr ? 32'h0 : model_read(addr, n);
      do_txn($sformatf("rnd%0d", t), is_ls, is_wr, n, addr, wdata, is_wr ? n : n + 1, e, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
